// File: rtl/psum_accumulator.sv
// Per-column signed accumulator for the systolic array, drained through a valid/ready write port.
// Optional macro ACC_SAT_EN: saturating lane and reduction arithmetic with a sticky acc_overflow flag.
module psum_accumulator #(
    parameter int ARR_SIZE    = 4,
    parameter int VERTICAL_BW = 32,
    parameter int ACC_BW      = 32,
    parameter int ADDR_W      = 4,
    parameter int AUTO_CLEAR  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            acc_clear,
    input  logic                            in_valid,
    input  logic [ARR_SIZE*VERTICAL_BW-1:0] in_psum,
    input  logic                            store_output,
    input  logic                            reduce_mode,
    input  logic [ADDR_W-1:0]               op_buffer_address,
    output logic                            busy,
    output logic [ACC_BW-1:0]               output_data,
    output logic [ADDR_W-1:0]               output_buffer_addr,
    output logic                            output_buffer_enable,
    input  logic                            output_buffer_ready,
    output logic                            acc_overflow
);

    localparam int IDX_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARR_SIZE - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                   state;
    logic signed [ACC_BW-1:0] lane     [ARR_SIZE];
    logic signed [ACC_BW-1:0] col_ext  [ARR_SIZE];
    logic signed [ACC_BW-1:0] lane_add [ARR_SIZE];
    logic signed [ACC_BW-1:0] lane_nxt [ARR_SIZE];
    logic signed [ACC_BW-1:0] red_sum;
    logic [IDX_W-1:0]         idx;
    logic                     red_q;

`ifdef ACC_SAT_EN
    localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

    logic [ARR_SIZE-1:0] lane_sat;
    logic                red_sat;
    logic [ACC_BW:0]     red_step;
    logic                ovf_q;

    // Returns {saturated, result}; overflow only when both operands share a sign the sum lost.
    function automatic logic [ACC_BW:0] sat_add(input logic signed [ACC_BW-1:0] a,
                                                input logic signed [ACC_BW-1:0] b);
        logic signed [ACC_BW-1:0] s;
        s = a + b;
        if ((a[ACC_BW-1] == b[ACC_BW-1]) && (s[ACC_BW-1] != a[ACC_BW-1]))
            return {1'b1, (a[ACC_BW-1] ? ACC_MIN : ACC_MAX)};
        return {1'b0, s};
    endfunction
`endif

    always_comb begin
        for (int unsigned k = 0; k < ARR_SIZE; k++) begin
            col_ext[k] = ACC_BW'(signed'(in_psum[k*VERTICAL_BW +: VERTICAL_BW]));
`ifdef ACC_SAT_EN
            {lane_sat[k], lane_add[k]} = sat_add(lane[k], col_ext[k]);
`else
            lane_add[k] = lane[k] + col_ext[k];
`endif
            if (acc_clear)
                lane_nxt[k] = '0;
            else if (in_valid)
                lane_nxt[k] = lane_add[k];
            else
                lane_nxt[k] = lane[k];
        end
    end

    // Reduction runs on the post-update lanes so a same-cycle beat or clear is included.
    always_comb begin
        red_sum = '0;
`ifdef ACC_SAT_EN
        red_sat  = 1'b0;
        red_step = '0;
`endif
        for (int unsigned k = 0; k < ARR_SIZE; k++) begin
`ifdef ACC_SAT_EN
            red_step = sat_add(red_sum, lane_nxt[k]);
            red_sat  = red_sat | red_step[ACC_BW];
            red_sum  = red_step[ACC_BW-1:0];
`else
            red_sum = red_sum + lane_nxt[k];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            lane                 <= '{default: '0};
            idx                  <= '0;
            red_q                <= 1'b0;
            busy                 <= 1'b0;
            output_data          <= '0;
            output_buffer_addr   <= '0;
            output_buffer_enable <= 1'b0;
`ifdef ACC_SAT_EN
            ovf_q                <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    lane <= lane_nxt;
`ifdef ACC_SAT_EN
                    if (acc_clear)
                        ovf_q <= 1'b0;
                    else if ((in_valid && (|lane_sat)) || (store_output && reduce_mode && red_sat))
                        ovf_q <= 1'b1;
`endif
                    if (store_output) begin
                        red_q                <= reduce_mode;
                        idx                  <= '0;
                        output_buffer_addr   <= op_buffer_address;
                        output_data          <= reduce_mode ? red_sum : lane_nxt[0];
                        output_buffer_enable <= 1'b1;
                        busy                 <= 1'b1;
                        state                <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (output_buffer_enable && output_buffer_ready) begin
                        if (red_q || (idx == LAST_IDX)) begin
                            output_buffer_enable <= 1'b0;
                            busy                 <= 1'b0;
                            state                <= IDLE;
                            if (AUTO_CLEAR != 0)
                                lane <= '{default: '0};
                        end else begin
                            idx                <= idx + IDX_W'(1);
                            output_buffer_addr <= output_buffer_addr + ADDR_W'(1);
                            output_data        <= lane[idx + IDX_W'(1)];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ACC_SAT_EN
    assign acc_overflow = ovf_q;
`else
    assign acc_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: table of drain vectors plus stall, same-cycle, reset and overflow sequences.
module tb_psum_accumulator;

    logic         clk = 1'b0;
    logic         rst;
    logic         acc_clear;
    logic         in_valid;
    logic [127:0] in_psum;
    logic         store_output;
    logic         reduce_mode;
    logic [3:0]   op_buffer_address;
    logic         busy;
    logic [31:0]  output_data;
    logic [3:0]   output_buffer_addr;
    logic         output_buffer_enable;
    logic         output_buffer_ready;
    logic         acc_overflow;

    always #5 clk = ~clk;

    psum_accumulator #(
        .ARR_SIZE   (4),
        .VERTICAL_BW(32),
        .ACC_BW     (32),
        .ADDR_W     (4),
        .AUTO_CLEAR (1)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .acc_clear           (acc_clear),
        .in_valid            (in_valid),
        .in_psum             (in_psum),
        .store_output        (store_output),
        .reduce_mode         (reduce_mode),
        .op_buffer_address   (op_buffer_address),
        .busy                (busy),
        .output_data         (output_data),
        .output_buffer_addr  (output_buffer_addr),
        .output_buffer_enable(output_buffer_enable),
        .output_buffer_ready (output_buffer_ready),
        .acc_overflow        (acc_overflow)
    );

    typedef struct packed {
        logic [2:0]   nb;
        logic [127:0] p;
        logic         red;
        logic [3:0]   base;
        logic [2:0]   nexp;
        logic [127:0] ed;
        logic [15:0]  ea;
    } vec_t;

    vec_t        vt [5];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] got_d [8];
    logic [3:0]  got_a [8];
    int          got_c [8];
    int          n_got;
    logic [31:0] exp_lane0;
    logic        exp_ovf;

    function automatic logic [127:0] mk(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [15:0] mka(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic [3:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        acc_clear    = 1'b0;
        store_output = 1'b0;
    endtask

    task automatic beat(input logic [127:0] p);
        @(negedge clk);
        idle();
        in_valid = 1'b1;
        in_psum  = p;
    endtask

    task automatic store(input logic red, input logic [3:0] base, input logic with_valid,
                         input logic with_clear, input logic [127:0] p);
        @(negedge clk);
        store_output      = 1'b1;
        reduce_mode       = red;
        op_buffer_address = base;
        in_valid          = with_valid;
        acc_clear         = with_clear;
        in_psum           = p;
    endtask

    // Drives ready and records each handshake; ready is withheld for stall_n cycles on word stall_word.
    task automatic collect(input int stall_word, input int stall_n);
        int          stalls;
        bit          done;
        logic [31:0] hd;
        logic [3:0]  ha;
        stalls = 0;
        done   = 1'b0;
        hd     = '0;
        ha     = '0;
        n_got  = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            idle();
            if (!output_buffer_enable) begin
                chk("busy_after_drain", {31'd0, busy}, 32'd0);
                done = 1'b1;
            end else if (n_got == stall_word && stalls < stall_n) begin
                if (stalls == 0) begin
                    hd = output_data;
                    ha = output_buffer_addr;
                end else begin
                    chk("stall_data_hold", output_data, hd);
                    chk("stall_addr_hold", {28'd0, output_buffer_addr}, {28'd0, ha});
                end
                stalls++;
                output_buffer_ready = 1'b0;
            end else begin
                if (stalls > 0 && n_got == stall_word)
                    chk("stall_release_data", output_data, hd);
                output_buffer_ready = 1'b1;
                if (n_got < 8) begin
                    got_d[n_got] = output_data;
                    got_a[n_got] = output_buffer_addr;
                    got_c[n_got] = c;
                end
                n_got++;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: enable still high after 40 cycles, writes seen %0d", n_got);
        end
        output_buffer_ready = 1'b1;
    endtask

    initial begin
        rst                 = 1'b0;
        acc_clear           = 1'b0;
        in_valid            = 1'b0;
        in_psum             = '0;
        store_output        = 1'b0;
        reduce_mode         = 1'b0;
        op_buffer_address   = '0;
        output_buffer_ready = 1'b1;

        vt[0] = '{nb: 3'd3, p: mk(1, 2, 3, 4), red: 1'b1, base: 4'd5, nexp: 3'd1,
                  ed: mk(30, 0, 0, 0), ea: mka(5, 0, 0, 0)};
        vt[1] = '{nb: 3'd2, p: mk(10, 32'hFFFF_FFFD, 7, 0), red: 1'b0, base: 4'd14, nexp: 3'd4,
                  ed: mk(20, 32'hFFFF_FFFA, 14, 0), ea: mka(14, 15, 0, 1)};
        vt[2] = '{nb: 3'd0, p: '0, red: 1'b1, base: 4'd9, nexp: 3'd1,
                  ed: mk(0, 0, 0, 0), ea: mka(9, 0, 0, 0)};
        vt[3] = '{nb: 3'd1, p: mk(32'hFFFF_FFFB, 2, 32'hFFFF_FFF8, 1), red: 1'b1, base: 4'd15, nexp: 3'd1,
                  ed: mk(32'hFFFF_FFF6, 0, 0, 0), ea: mka(15, 0, 0, 0)};
        vt[4] = '{nb: 3'd1, p: mk(100, 200, 300, 400), red: 1'b0, base: 4'd3, nexp: 3'd4,
                  ed: mk(100, 200, 300, 400), ea: mka(3, 4, 5, 6)};

        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_enable", {31'd0, output_buffer_enable}, 32'd0);
        chk("rst_data", output_data, 32'd0);
        chk("rst_addr", {28'd0, output_buffer_addr}, 32'd0);
        chk("rst_ovf", {31'd0, acc_overflow}, 32'd0);
        rst = 1'b1;

        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < int'(vt[v].nb); b++)
                beat(vt[v].p);
            store(vt[v].red, vt[v].base, 1'b0, 1'b0, '0);
            collect(-1, 0);
            chk($sformatf("vec%0d_nwrites", v), n_got, {29'd0, vt[v].nexp});
            for (int i = 0; i < int'(vt[v].nexp) && i < n_got; i++) begin
                chk($sformatf("vec%0d_data%0d", v, i), got_d[i], vt[v].ed[32*i +: 32]);
                chk($sformatf("vec%0d_addr%0d", v, i), {28'd0, got_a[i]}, {28'd0, vt[v].ea[4*i +: 4]});
                if (i > 0)
                    chk($sformatf("vec%0d_gap%0d", v, i), got_c[i] - got_c[i-1], 32'd1);
            end
        end

        // Ready held low for three cycles on the second per-column word.
        beat(mk(1, 2, 3, 4));
        store(1'b0, 4'd0, 1'b0, 1'b0, '0);
        collect(1, 3);
        chk("stall_nwrites", n_got, 32'd4);
        for (int i = 0; i < 4 && i < n_got; i++) begin
            chk($sformatf("stall_data%0d", i), got_d[i], i + 1);
            chk($sformatf("stall_addr%0d", i), {28'd0, got_a[i]}, i);
        end

        // Beat accepted together with the store is included; a same-cycle clear wins over the beat.
        beat(mk(1, 1, 1, 1));
        store(1'b1, 4'd0, 1'b1, 1'b0, mk(1, 1, 1, 1));
        collect(-1, 0);
        chk("same_cycle_add_n", n_got, 32'd1);
        chk("same_cycle_add_data", got_d[0], 32'd8);
        beat(mk(5, 5, 5, 5));
        store(1'b1, 4'd0, 1'b1, 1'b1, mk(9, 9, 9, 9));
        collect(-1, 0);
        chk("same_cycle_clear_n", n_got, 32'd1);
        chk("same_cycle_clear_data", got_d[0], 32'd0);

        // Reset after the first of four per-column writes.
        beat(mk(1, 2, 3, 4));
        store(1'b0, 4'd8, 1'b0, 1'b0, '0);
        @(negedge clk);
        idle();
        chk("abort_first_data", output_data, 32'd1);
        chk("abort_first_addr", {28'd0, output_buffer_addr}, 32'd8);
        @(negedge clk);
        chk("abort_second_data", output_data, 32'd2);
        rst = 1'b0;
        #1;
        chk("abort_enable", {31'd0, output_buffer_enable}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_data", output_data, 32'd0);
        chk("abort_addr", {28'd0, output_buffer_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_still_idle", {31'd0, output_buffer_enable}, 32'd0);
        store(1'b1, 4'd2, 1'b0, 1'b0, '0);
        collect(-1, 0);
        chk("post_abort_n", n_got, 32'd1);
        chk("post_abort_data", got_d[0], 32'd0);
        chk("post_abort_addr", {28'd0, got_a[0]}, 32'd2);

        // Lane 0 pushed past the positive limit.
`ifdef ACC_SAT_EN
        exp_lane0 = 32'h7FFF_FFFF;
        exp_ovf   = 1'b1;
`else
        exp_lane0 = 32'h8000_0010;
        exp_ovf   = 1'b0;
`endif
        beat(mk(32'h7FFF_FFF0, 0, 0, 0));
        beat(mk(32'h0000_0020, 0, 0, 0));
        @(negedge clk);
        idle();
        chk("ovf_after_add", {31'd0, acc_overflow}, {31'd0, exp_ovf});
        store(1'b0, 4'd0, 1'b0, 1'b0, '0);
        collect(-1, 0);
        chk("ovf_lane_n", n_got, 32'd4);
        chk("ovf_lane0", got_d[0], exp_lane0);
        chk("ovf_held_after_drain", {31'd0, acc_overflow}, {31'd0, exp_ovf});
        @(negedge clk);
        acc_clear = 1'b1;
        @(negedge clk);
        idle();
        chk("ovf_cleared", {31'd0, acc_overflow}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
